sha3_result_collector: RTL and testbench

- Sits directly downstream of the packed-by-6 scanner.
- On each found pulse it captures the winning nonce and one selected 64-bit hash word into a small FIFO.
- Drains entries to the host side as a 32-bit valid/ready beat stream, three beats per entry.
- Counts results lost to FIFO overflow so the host can detect missed solutions.

---
 rtl/sha3_result_collector.sv | 119 +++++++++++
 tb/tb_sha3_result_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sha3_result_collector.sv
// Result collector behind the SHA3 nonce scanner: buffers {nonce, hash word}
// per found pulse and drains each entry as three 32-bit valid/ready beats.
module sha3_result_collector #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned HASH_WORD = 0,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     found,
  input  logic [24:0][63:0]        hash,
  input  logic [31:0]              nonce,
  input  logic                     flush,
  input  logic                     clear,
  output logic                     ovalid,
  output logic [31:0]              odata,
  output logic                     olast,
  input  logic                     oready,
  output logic [$clog2(DEPTH):0]   ocount,
  output logic [DROP_W-1:0]        odropped,
  output logic                     ooverflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 96;
  localparam logic [4:0]  HW = 5'(HASH_WORD);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     waddr;
  logic [1:0]        beat;
  logic [CW-1:0]     count;
  logic [DROP_W-1:0] drops;
  logic              ovf;
  logic [EW-1:0]     entry;
  logic [EW-1:0]     head;
  logic              xfer;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;

  // A full FIFO still accepts a push when the head entry leaves in the same cycle;
  // flush empties the FIFO first, so a found during flush always lands in slot 0.
  always_comb begin
    xfer  = ovalid && oready;
    pop   = xfer && (beat == 2'd2);
    full  = (count == CW'(DEPTH));
    push  = found && (flush || !full || pop);
    drop  = found && !flush && full && !pop;
    entry = {nonce, hash[HW]};
    waddr = flush ? '0 : wptr;
    head  = mem[rptr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr  <= '0;
      wptr  <= '0;
      beat  <= 2'd0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= push ? AW'(1) : '0;
      beat  <= 2'd0;
      count <= CW'(push);
    end else begin
      if (xfer) beat <= pop ? 2'd0 : beat + 2'd1;
      if (pop)  rptr <= rptr + AW'(1);
      if (push) wptr <= wptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: it is only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem[waddr] <= entry;
  end

  // A drop in the same cycle as clear leaves a count of one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drops <= '0;
      ovf   <= 1'b0;
    end else if (drop) begin
      drops <= clear ? DROP_W'(1) : ((drops == DROP_MAX) ? drops : drops + DROP_W'(1));
      ovf   <= 1'b1;
    end else if (clear) begin
      drops <= '0;
      ovf   <= 1'b0;
    end
  end

  // Beat decode straight from registered state; no input reaches the outputs.
  always_comb begin
    odata = '0;
    olast = 1'b0;
    if (count != '0) begin
      case (beat)
        2'd0:    odata = head[95:64];
        2'd1:    odata = head[31:0];
        2'd2: begin
          odata = head[63:32];
          olast = 1'b1;
        end
        default: odata = '0;
      endcase
    end
  end

  assign ovalid    = (count != '0);
  assign ocount    = count;
  assign odropped  = drops;
  assign ooverflow = ovf;

endmodule

// File: tb/tb_sha3_result_collector.sv
// Scoreboard bench for sha3_result_collector: a beat-queue reference model,
// directed scenarios, randomized traffic, and a second instance with a 2-bit drop counter.
module tb_sha3_result_collector;

  localparam int unsigned DEPTH = 4;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               found = 1'b0;
  logic               flush = 1'b0;
  logic               clear = 1'b0;
  logic               oready = 1'b0;
  logic [24:0][63:0]  hash = '0;
  logic [31:0]        nonce = '0;

  logic               ovalid, olast, ooverflow;
  logic [31:0]        odata;
  logic [2:0]         ocount;
  logic [7:0]         odropped;

  logic               s_ovalid, s_olast, s_ooverflow;
  logic [31:0]        s_odata;
  logic [2:0]         s_ocount;
  logic [1:0]         s_odropped;

  sha3_result_collector #(.DEPTH(DEPTH), .HASH_WORD(0), .DROP_W(8)) dut (
    .clk(clk), .rstn(rstn), .found(found), .hash(hash), .nonce(nonce),
    .flush(flush), .clear(clear), .ovalid(ovalid), .odata(odata), .olast(olast),
    .oready(oready), .ocount(ocount), .odropped(odropped), .ooverflow(ooverflow)
  );

  sha3_result_collector #(.DEPTH(DEPTH), .HASH_WORD(24), .DROP_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .found(found), .hash(hash), .nonce(nonce),
    .flush(flush), .clear(clear), .ovalid(s_ovalid), .odata(s_odata), .olast(s_olast),
    .oready(oready), .ocount(s_ocount), .odropped(s_odropped), .ooverflow(s_ooverflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    d8, d2;
  bit    ovf_m;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor + model: compare presented outputs, then advance the reference for the coming edge.
  int    n, ent;
  bit    xfer_m, last_m, drop_m;
  beat_t b;
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      d8 = 0; d2 = 0; ovf_m = 0;
      chk("rst_ovalid", ovalid, 0);
      chk("rst_odata", odata, 0);
      chk("rst_ocount", ocount, 0);
      chk("rst_odropped", odropped, 0);
    end else begin
      n   = exp_q.size();
      ent = (n + 2) / 3;
      chk("ovalid", ovalid, n != 0);
      chk("ocount", ocount, ent);
      chk("odata", odata, (n != 0) ? exp_q[0].d : 32'h0);
      chk("olast", olast, (n != 0) ? exp_q[0].l : 1'b0);
      chk("odropped", odropped, d8);
      chk("ooverflow", ooverflow, ovf_m);
      chk("sat_ocount", s_ocount, ent);
      chk("sat_odropped", s_odropped, d2);
      chk("sat_ooverflow", s_ooverflow, ovf_m);

      xfer_m = (n != 0) && oready;
      last_m = xfer_m && exp_q[0].l;
      drop_m = 0;
      if (flush) exp_q.delete();
      else if (xfer_m) void'(exp_q.pop_front());
      if (found) begin
        if (flush || ent < DEPTH || last_m) begin
          b.d = nonce;             b.l = 0; exp_q.push_back(b);
          b.d = hash[0][31:0];     b.l = 0; exp_q.push_back(b);
          b.d = hash[0][63:32];    b.l = 1; exp_q.push_back(b);
        end else begin
          drop_m = 1;
        end
      end
      if (drop_m) begin
        d8 = clear ? 1 : ((d8 < 255) ? d8 + 1 : 255);
        d2 = clear ? 1 : ((d2 < 3) ? d2 + 1 : 3);
        ovf_m = 1;
      end else if (clear) begin
        d8 = 0; d2 = 0; ovf_m = 0;
      end
    end
  end

  task automatic drive(input bit f, input logic [31:0] nn, input logic [63:0] h0,
                       input bit r, input bit fl = 0, input bit cl = 0);
    found = f; nonce = nn; oready = r; flush = fl; clear = cl;
    for (int i = 0; i < 25; i++) hash[i] = {$urandom, $urandom};
    hash[0] = h0;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rh();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;

    // single entry, oready high
    drive(1, 32'h0000_1234, 64'hDEAD_BEEF_CAFE_F00D, 1);
    repeat (5) drive(0, 0, rh(), 1);

    // backpressure with pattern 1,0,0,1,...
    drive(1, 32'hA1, rh(), 0);
    drive(1, 32'hA2, rh(), 0);
    for (int i = 0; i < 18; i++) drive(0, 0, rh(), (i % 3) == 0);

    // overflow: six founds into a depth-4 FIFO with no drain
    for (int i = 1; i <= 6; i++) drive(1, 32'(i), rh(), 0);
    chk("ovf_ocount", ocount, 4);
    chk("ovf_odropped", odropped, 2);
    chk("ovf_sticky", ooverflow, 1);
    repeat (14) drive(0, 0, rh(), 1);
    drive(0, 0, rh(), 0, 0, 1);
    chk("clr_odropped", odropped, 0);
    chk("clr_overflow", ooverflow, 0);

    // full with pop and push in the same cycle
    for (int i = 11; i <= 14; i++) drive(1, 32'(i), rh(), 0);
    drive(0, 0, rh(), 1);
    drive(0, 0, rh(), 1);
    drive(1, 32'h9, rh(), 1);
    chk("full_pp_ocount", ocount, 4);
    chk("full_pp_drops", odropped, 0);
    repeat (14) drive(0, 0, rh(), 1);

    // saturation: five drops into a 2-bit counter
    for (int i = 0; i < 9; i++) drive(1, 32'h100 + 32'(i), rh(), 0);
    chk("sat_5drops", s_odropped, 3);
    chk("wide_5drops", odropped, 5);
    drive(1, 32'h200, rh(), 0, 0, 1);
    chk("clr_drop_wins", odropped, 1);
    drive(0, 0, rh(), 0, 0, 1);
    repeat (14) drive(0, 0, rh(), 1);

    // flush mid-entry with a found in the same cycle
    for (int i = 0; i < 3; i++) drive(1, 32'h300 + 32'(i), rh(), 0);
    drive(0, 0, rh(), 1);
    drive(1, 32'h55, rh(), 1, 1);
    chk("flush_ocount", ocount, 1);
    chk("flush_beat0", odata, 32'h55);
    repeat (5) drive(0, 0, rh(), 1);

    // randomized traffic
    for (int i = 0; i < 500; i++)
      drive($urandom_range(0, 1) == 1, $urandom, rh(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);
    drive(0, 0, rh(), 0, 0, 1);
    repeat (14) drive(0, 0, rh(), 1);

    // async reset asserted mid-drain, away from any clock edge
    for (int i = 0; i < 3; i++) drive(1, 32'h400 + 32'(i), rh(), 0);
    drive(0, 0, rh(), 1);
    drive(0, 0, rh(), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ovalid", ovalid, 0);
    chk("arst_odata", odata, 0);
    chk("arst_olast", olast, 0);
    chk("arst_ocount", ocount, 0);
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;
    drive(1, 32'h77, rh(), 1);
    repeat (4) drive(0, 0, rh(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
